// File: rtl/fft_out_reorder_pkg.sv
// Shared bank/read-state encodings and the bit-reverse helper for the FFT output reorder buffer.
package fft_out_reorder_pkg;

   typedef enum logic [1:0] {
      BANK_EMPTY    = 2'd0,
      BANK_FILLING  = 2'd1,
      BANK_FULL     = 2'd2,
      BANK_DRAINING = 2'd3
   } bank_state_e;

   typedef enum logic {
      RD_IDLE  = 1'b0,
      RD_DRAIN = 1'b1
   } rd_state_e;

   // Reverse the low w bits of x; bits at and above w come back as zero.
   function automatic logic [31:0] bitrev(input logic [31:0] x, input int unsigned w);
      logic [31:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (i < w) r[5'(i)] = x[5'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_reorder_if.sv
// Stage-stream write side plus valid/ready replay side of the FFT output reorder buffer.
interface fft_out_reorder_if #(
   parameter int unsigned TOTAL_STAGE_P = 10,
   parameter int unsigned MULT_WIDTH_P  = 18
);
   logic                        ien;
   logic [TOTAL_STAGE_P-1:0]    iaddr;
   logic [2*MULT_WIDTH_P-1:0]   idata;
   logic                        ovalid;
   logic                        ordy;
   logic [2*MULT_WIDTH_P-1:0]   odata;
   logic [TOTAL_STAGE_P-1:0]    oidx;
   logic                        olast;
   logic                        ovf;

   // master: FFT stage feeding samples and the downstream consumer giving ready
   modport master (
      output ien, iaddr, idata, ordy,
      input  ovalid, odata, oidx, olast, ovf
   );

   // slave: the reorder buffer itself
   modport slave (
      input  ien, iaddr, idata, ordy,
      output ovalid, odata, oidx, olast, ovf
   );
endinterface

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample RAM: one write port, one synchronous 1-cycle read port; address MSB selects the bank.
module fft_pingpong_ram #(
   parameter int unsigned IDX_W  = 10,
   parameter int unsigned DATA_W = 36
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W:0]    waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W:0]    raddr,
   output logic [DATA_W-1:0] rdata
);
   localparam int unsigned DEPTH = 2 ** (IDX_W + 1);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // rdata holds its value while re is low; the reader relies on this as a storage slot
   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/fft_out_reorder.sv
// FFT output reorder: captures address-scattered frames into ping-pong banks and replays them in index order.
// Optional build macro FFT_OUT_BITREV_EN reads bank entries at bitrev(rcnt) instead of rcnt.
module fft_out_reorder
   import fft_out_reorder_pkg::*;
#(
   parameter int unsigned TOTAL_STAGE_P = 10,
   parameter int unsigned MULT_WIDTH_P  = 18
) (
   input logic               iclk,
   input logic               rst,
   fft_out_reorder_if.slave  bus
);
   localparam int unsigned N          = 2 ** TOTAL_STAGE_P;
   localparam int unsigned CPLX_WIDTH = 2 * MULT_WIDTH_P;
   localparam logic [TOTAL_STAGE_P-1:0] LAST_IDX = TOTAL_STAGE_P'(N - 1);

   bank_state_e                bank_st [2];
   logic                       wb;
   logic                       rb;
   logic [TOTAL_STAGE_P-1:0]   wcnt;
   logic [TOTAL_STAGE_P-1:0]   rcnt;
   logic                       wr_ok;

   rd_state_e                  state;
   rd_state_e                  state_nxt;
   logic                       drain_start;
   logic                       drain_end;
   logic                       re;
   logic                       rd_all;
   logic                       rd_vld;
   logic [TOTAL_STAGE_P-1:0]   rd_idx;
   logic [TOTAL_STAGE_P:0]     raddr;
   logic [CPLX_WIDTH-1:0]      rdata;

   logic                       pop;
   logic                       move;
   logic                       s_valid;
   logic [CPLX_WIDTH-1:0]      s_data;
   logic [TOTAL_STAGE_P-1:0]   s_idx;
   logic                       s_last;

   assign wr_ok = bus.ien && (bank_st[wb] == BANK_EMPTY || bank_st[wb] == BANK_FILLING);
   assign pop   = bus.ovalid && bus.ordy;
   // RAM output moves into the skid stage whenever at least one slot is free, independent of ordy
   assign move  = rd_vld && !(bus.ovalid && s_valid);

`ifdef FFT_OUT_BITREV_EN
   assign raddr = {rb, TOTAL_STAGE_P'(bitrev(32'(rcnt), TOTAL_STAGE_P))};
`else
   assign raddr = {rb, rcnt};
`endif

   fft_pingpong_ram #(
      .IDX_W  (TOTAL_STAGE_P),
      .DATA_W (CPLX_WIDTH)
   ) u_ram (
      .clk   (iclk),
      .we    (wr_ok),
      .waddr ({wb, bus.iaddr}),
      .wdata (bus.idata),
      .re    (re),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Write side: bank fill tracking and sticky overflow
   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         bank_st[0] <= BANK_EMPTY;
         bank_st[1] <= BANK_EMPTY;
         wb         <= 1'b0;
         wcnt       <= '0;
         bus.ovf    <= 1'b0;
      end else begin
         if (wr_ok) begin
            if (wcnt == LAST_IDX) begin
               bank_st[wb] <= BANK_FULL;
               wb          <= ~wb;
               wcnt        <= '0;
            end else begin
               bank_st[wb] <= BANK_FILLING;
               wcnt        <= wcnt + TOTAL_STAGE_P'(1);
            end
         end else if (bus.ien) begin
            bus.ovf <= 1'b1;
         end
         // the state rules keep rb off the bank being written here
         if (drain_start) bank_st[rb] <= BANK_DRAINING;
         if (drain_end)   bank_st[rb] <= BANK_EMPTY;
      end
   end

   // Read FSM state register and read-side counters
   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         state  <= RD_IDLE;
         rb     <= 1'b0;
         rcnt   <= '0;
         rd_all <= 1'b0;
         rd_vld <= 1'b0;
         rd_idx <= '0;
      end else begin
         state <= state_nxt;
         if (drain_start) begin
            rcnt   <= '0;
            rd_all <= 1'b0;
         end else if (re) begin
            rcnt   <= rcnt + TOTAL_STAGE_P'(1);
            rd_all <= (rcnt == LAST_IDX);
         end
         if (re) begin
            rd_vld <= 1'b1;
            rd_idx <= rcnt;
         end else if (move) begin
            rd_vld <= 1'b0;
         end
         if (drain_end) rb <= ~rb;
      end
   end

   // Read FSM next state and read strobes
   always_comb begin
      state_nxt   = state;
      drain_start = 1'b0;
      drain_end   = 1'b0;
      re          = 1'b0;
      case (state)
         RD_IDLE: begin
            if (bank_st[rb] == BANK_FULL) begin
               state_nxt   = RD_DRAIN;
               drain_start = 1'b1;
            end
         end
         RD_DRAIN: begin
            re = !rd_all && (!rd_vld || move);
            if (pop && bus.olast) begin
               state_nxt = RD_IDLE;
               drain_end = 1'b1;
            end
         end
         default: state_nxt = RD_IDLE;
      endcase
   end

   // Two-entry output stage: main register drives the port, skid catches a beat during a stall
   always_ff @(posedge iclk or posedge rst) begin
      if (rst) begin
         bus.ovalid <= 1'b0;
         bus.odata  <= '0;
         bus.oidx   <= '0;
         bus.olast  <= 1'b0;
         s_valid    <= 1'b0;
         s_data     <= '0;
         s_idx      <= '0;
         s_last     <= 1'b0;
      end else if (!bus.ovalid || pop) begin
         if (s_valid) begin
            bus.ovalid <= 1'b1;
            bus.odata  <= s_data;
            bus.oidx   <= s_idx;
            bus.olast  <= s_last;
            s_valid    <= 1'b0;
         end else begin
            bus.ovalid <= move;
            if (move) begin
               bus.odata <= rdata;
               bus.oidx  <= rd_idx;
               bus.olast <= (rd_idx == LAST_IDX);
            end
         end
      end else if (move) begin
         s_valid <= 1'b1;
         s_data  <= rdata;
         s_idx   <= rd_idx;
         s_last  <= (rd_idx == LAST_IDX);
      end
   end
endmodule

// File: tb/tb_fft_out_reorder.sv
// Scoreboard bench for fft_out_reorder at N=8; also covers the FFT_OUT_BITREV_EN build.
module tb_fft_out_reorder;
   typedef struct packed {
      logic [35:0] data;
      logic [2:0]  idx;
      logic        last;
   } exp_t;

   logic iclk;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];

   logic        hold_pending = 1'b0;
   logic [35:0] h_data;
   logic [2:0]  h_idx;
   logic        h_last;

   fft_out_reorder_if #(.TOTAL_STAGE_P(3), .MULT_WIDTH_P(18)) bus ();

   fft_out_reorder #(.TOTAL_STAGE_P(3), .MULT_WIDTH_P(18)) dut (
      .iclk (iclk),
      .rst  (rst),
      .bus  (bus.slave)
   );

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // which stored entry the DUT reads for output index k
   function automatic logic [2:0] rd_map(input logic [2:0] k);
`ifdef FFT_OUT_BITREV_EN
      case (k)
         3'd0: return 3'd0;
         3'd1: return 3'd4;
         3'd2: return 3'd2;
         3'd3: return 3'd6;
         3'd4: return 3'd1;
         3'd5: return 3'd5;
         3'd6: return 3'd3;
         default: return 3'd7;
      endcase
`else
      return k;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wr(input logic [2:0] a, input logic [35:0] d);
      bus.ien   = 1'b1;
      bus.iaddr = a;
      bus.idata = d;
      @(posedge iclk); #1;
      bus.ien   = 1'b0;
   endtask

   // one frame of data = base + address; expected beats queued only when the frame should survive
   task automatic write_frame(input logic [35:0] base, input bit rev, input bit expect_out);
      for (int i = 0; i < 8; i++) begin
         logic [2:0] a;
         a = rev ? 3'(7 - i) : 3'(i);
         wr(a, base + 36'(a));
      end
      if (expect_out) begin
         for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.data = base + 36'(rd_map(3'(k)));
            e.idx  = 3'(k);
            e.last = (k == 7);
            sb.push_back(e);
         end
      end
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (sb.size() != 0 && n < budget) begin
         @(posedge iclk); #1;
         n++;
      end
      chk("drain_left", 64'(sb.size()), 64'd0);
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.ien  = 1'b0;
      bus.ordy = 1'b0;
      sb.delete();
      repeat (2) @(posedge iclk);
      #1;
      chk("rst_ovalid", 64'(bus.ovalid), 64'd0);
      chk("rst_odata",  64'(bus.odata),  64'd0);
      chk("rst_oidx",   64'(bus.oidx),   64'd0);
      chk("rst_olast",  64'(bus.olast),  64'd0);
      chk("rst_ovf",    64'(bus.ovf),    64'd0);
      rst = 1'b0;
   endtask

   // Monitor: pops the scoreboard on every handshake and checks stall stability
   always @(negedge iclk) begin
      if (rst) begin
         hold_pending = 1'b0;
      end else begin
         if (hold_pending) begin
            checks++;
            if (!bus.ovalid || bus.odata !== h_data || bus.oidx !== h_idx || bus.olast !== h_last) begin
               errors++;
               $display("FAIL stall_hold: got v=%0b data=%0h idx=%0d last=%0b, expected v=1 data=%0h idx=%0d last=%0b",
                        bus.ovalid, bus.odata, bus.oidx, bus.olast, h_data, h_idx, h_last);
            end
         end
         if (bus.ovalid && bus.ordy) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got data=%0h idx=%0d, expected no output", bus.odata, bus.oidx);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (bus.odata !== e.data || bus.oidx !== e.idx || bus.olast !== e.last) begin
                  errors++;
                  $display("FAIL out_beat: got data=%0h idx=%0d last=%0b, expected data=%0h idx=%0d last=%0b",
                           bus.odata, bus.oidx, bus.olast, e.data, e.idx, e.last);
               end
            end
            hold_pending = 1'b0;
         end else if (bus.ovalid) begin
            hold_pending = 1'b1;
            h_data = bus.odata;
            h_idx  = bus.oidx;
            h_last = bus.olast;
         end else begin
            hold_pending = 1'b0;
         end
      end
   end

   initial begin
      bit found;
      rst       = 1'b1;
      bus.ien   = 1'b0;
      bus.iaddr = '0;
      bus.idata = '0;
      bus.ordy  = 1'b0;

      // reversed-address frame with ordy held high, including 3-cycle latency
      do_reset();
      bus.ordy = 1'b1;
      write_frame(36'h100, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge iclk); #1;
         chk($sformatf("latency_ovalid_c%0d", k), 64'(bus.ovalid), (k == 3) ? 64'd1 : 64'd0);
      end
      wait_drain(100);
      chk("ovf_after_frame1", 64'(bus.ovf), 64'd0);

      // back-pressure with ordy pattern 1,0,0
      write_frame(36'h100, 1'b1, 1'b1);
      for (int c = 0; c < 200 && sb.size() != 0; c++) begin
         bus.ordy = (c % 3 == 0);
         @(posedge iclk); #1;
      end
      chk("bp_left", 64'(sb.size()), 64'd0);
      bus.ordy = 1'b1;
      repeat (4) @(posedge iclk);
      #1;

      // overflow: three frames while stalled, third is dropped
      bus.ordy = 1'b0;
      write_frame(36'h200, 1'b0, 1'b1);
      write_frame(36'h300, 1'b1, 1'b1);
      chk("ovf_two_frames", 64'(bus.ovf), 64'd0);
      write_frame(36'h400, 1'b0, 1'b0);
      chk("ovf_third_frame", 64'(bus.ovf), 64'd1);
      repeat (3) @(posedge iclk);
      #1;
      bus.ordy = 1'b1;
      wait_drain(200);
      repeat (12) @(posedge iclk);
      #1;
      chk("ovf_sticky", 64'(bus.ovf), 64'd1);

      // release race: write coinciding with the final handshake is dropped
      do_reset();
      write_frame(36'h800, 1'b0, 1'b1);
      write_frame(36'h900, 1'b1, 1'b1);
      chk("ovf_before_race", 64'(bus.ovf), 64'd0);
      bus.ordy = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         @(posedge iclk); #1;
         if (bus.ovalid && bus.olast) found = 1'b1;
      end
      chk("race_olast_seen", 64'(found), 64'd1);
      bus.ien   = 1'b1;
      bus.iaddr = 3'd0;
      bus.idata = 36'hDEAD;
      @(posedge iclk); #1;
      bus.ien   = 1'b0;
      chk("ovf_race_drop", 64'(bus.ovf), 64'd1);
      write_frame(36'hA00, 1'b0, 1'b1);
      wait_drain(200);

      // asynchronous reset in the middle of a drain and a partial fill
      bus.ordy = 1'b0;
      write_frame(36'hB00, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) wr(3'(i), 36'hC00 + 36'(i));
      repeat (3) @(posedge iclk);
      #1;
      chk("pre_rst_ovalid", 64'(bus.ovalid), 64'd1);
      #2 rst = 1'b1;
      sb.delete();
      #1;
      chk("arst_ovalid", 64'(bus.ovalid), 64'd0);
      chk("arst_odata",  64'(bus.odata),  64'd0);
      chk("arst_oidx",   64'(bus.oidx),   64'd0);
      chk("arst_olast",  64'(bus.olast),  64'd0);
      chk("arst_ovf",    64'(bus.ovf),    64'd0);
      @(posedge iclk); #1;
      rst = 1'b0;
      bus.ordy = 1'b1;
      write_frame(36'hD00, 1'b1, 1'b1);
      wait_drain(100);
      chk("ovf_after_rst", 64'(bus.ovf), 64'd0);

      // sequential-address frame: natural order normally, bit-reversed order with FFT_OUT_BITREV_EN
      write_frame(36'h0, 1'b0, 1'b1);
      wait_drain(100);
      repeat (5) @(posedge iclk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
